cu_edge_data_write_arbiter: RTL and testbench
=============================================

CU_EDGE_DATA_WRITE_ARBITER -- requirements
Module: cu_edge_data_write_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of write requesters; MAX_OUTSTANDING, default 16, write-credit limit; CNT_W, default $clog2(MAX_OUTSTANDING)+1, credit counter width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The ports SHALL be, clock and reset first:
- clock  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- enabled_in  in  1  block enable, registered once internally
- drain_in  in  1  stop new grants and wait for all responses
- req_valid  in  NUM_REQ  per-requester write request
- req_index  in  NUM_REQ*32  per-requester vertex index; slice i is [i*32+:32]
- req_data  in  NUM_REQ*32  per-requester write data
- req_cu_id  in  NUM_REQ*8  per-requester CU id
- req_ready  out  NUM_REQ  one-hot acceptance; at most one bit high
- write_buffer_full  in  1  downstream command buffer full
- write_response_valid  in  1  one write completion per cycle
- out_valid  out  1  granted write toward the write control
- out_index  out  32  granted index
- out_data  out  32  granted data
- out_cu_id  out  8  granted CU id
- outstanding_count  out  CNT_W  issued writes not yet completed
- issued_count  out  32  total accepted writes since reset
- idle_out  out  1  state DONE

Function
REQ-004 enabled is enabled_in registered. A low enabled forces state DISABLED on the next edge, from any state.
REQ-005 The FSM SHALL have four states:
- DISABLED -> RUN when enabled=1.
- RUN -> DRAIN when drain_in=1.
- DRAIN -> DONE when outstanding_count=0.
- DONE -> RUN when drain_in=0.
REQ-006 can_issue = (state==RUN) & ~write_buffer_full & (outstanding_count < MAX_OUTSTANDING).
REQ-007 req_ready SHALL be combinational: grant[i] & can_issue. grant is round-robin over req_valid, searching from rr_ptr upward with wrap to 0.
REQ-008 Acceptance occurs when req_valid[i] & req_ready[i]. On acceptance, rr_ptr <= (i+1) mod NUM_REQ. With no acceptance, rr_ptr holds.
REQ-009 On acceptance in cycle N, out_valid=1 in cycle N+1 with that requester's index, data and cu_id. Latency is exactly 1 cycle.
REQ-010 With no acceptance, out_valid=0 and out_index, out_data, out_cu_id are 0 the next cycle. The outputs are single-cycle pulses with no downstream stall.
REQ-011 outstanding_count SHALL update each cycle:
- +1 on acceptance.
- -1 on write_response_valid.
- Unchanged when both occur in the same cycle.
- A response while the count is 0 is ignored; the counter saturates at 0.
REQ-012 When outstanding_count=MAX_OUTSTANDING, all req_ready=0, even in a cycle with a response. Issuing resumes the cycle after the count drops.
REQ-013 issued_count +1 per acceptance; it wraps at 2^32.
REQ-014 Responses SHALL be counted in every state, including DISABLED.
REQ-015 No request SHALL be accepted in DISABLED, DRAIN or DONE.
REQ-016 idle_out = (state==DONE).
REQ-017 write_buffer_full SHALL be sampled in the same cycle as the grant. A full in cycle N blocks acceptance in cycle N only.

Reset
REQ-018 While rst=1, and asynchronously on its assertion, the following SHALL be cleared:
- enabled=0, state=DISABLED, rr_ptr=0
- outstanding_count=0, issued_count=0
- req_ready=0, out_valid=0, out_index=0, out_data=0, out_cu_id=0, idle_out=0
REQ-019 Reset asserted mid-operation SHALL discard in-flight grants and credits. No out_valid pulse may follow the reset release without a new acceptance.
REQ-020 After rst is released, the first acceptance SHALL be possible no earlier than the second rising edge with enabled_in=1.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Round-robin: NUM_REQ=4, all req_valid=4'b1111 held for 8 cycles, no full -> grant order 0,1,2,3,0,1,2,3; out_valid high in each following cycle; issued_count=8.
- Credit limit: no responses, 20 back-to-back requests from requester 2 -> exactly 16 accepted, outstanding_count=16, req_ready=0. Then one response -> count 15, next cycle one acceptance, count 16.
- Simultaneous events: outstanding_count=5, acceptance and write_response_valid in the same cycle -> count stays 5. A response at count 0 -> count stays 0.
- Backpressure: write_buffer_full=1 for 3 cycles while req_valid[1]=1 -> req_ready=0 for those 3 cycles; acceptance in the first cycle with full=0; out_index equals req_index slice 1 one cycle later.
- Drain: outstanding_count=3, drain_in=1 -> no grants; after 3 responses idle_out=1. drain_in=0 -> RUN, grants resume.
- Reset mid-operation: outstanding_count=7, acceptance pending, rst pulsed -> all outputs 0 immediately; no out_valid after release; counters 0.

Source files
------------

// File: rtl/cu_edge_data_write_arbiter.sv
// Round-robin arbiter that funnels per-requester edge-data writes into one
// write-control stream, bounded by a write-credit limit and a drain handshake.
module cu_edge_data_write_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  enabled_in,
    input  logic                  drain_in,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_index,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ*8-1:0]  req_cu_id,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  write_buffer_full,
    input  logic                  write_response_valid,
    output logic                  out_valid,
    output logic [31:0]           out_index,
    output logic [31:0]           out_data,
    output logic [7:0]            out_cu_id,
    output logic [CNT_W-1:0]      outstanding_count,
    output logic [31:0]           issued_count,
    output logic                  idle_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREQ_U = NUM_REQ;

    typedef enum logic [1:0] {
        DISABLED,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               enabled;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               found;
    logic               can_issue;
    logic               accept;
    logic               resp_eff;
    logic [31:0]        sel_index;
    logic [31:0]        sel_data;
    logic [7:0]         sel_cu_id;

    // Round-robin: first valid requester at or after rr_ptr, wrapping to 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            for (int unsigned i = 0; i < NREQ_U; i++) begin
                if (!found && req_valid[i] && (i == (32'(rr_ptr) + k) % NREQ_U)) begin
                    grant[i]  = 1'b1;
                    grant_idx = PTR_W'(i);
                    found     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_index = '0;
        sel_data  = '0;
        sel_cu_id = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (grant[i]) begin
                sel_index = req_index[i*32 +: 32];
                sel_data  = req_data[i*32 +: 32];
                sel_cu_id = req_cu_id[i*8 +: 8];
            end
        end
    end

    assign can_issue = (state == RUN) && !write_buffer_full
                       && (outstanding_count < CNT_W'(MAX_OUTSTANDING));
    assign req_ready = can_issue ? grant : '0;
    assign accept    = can_issue && found;
    assign resp_eff  = write_response_valid && (outstanding_count != '0);
    assign rr_next   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign idle_out  = (state == DONE);

    // A dropped enable overrides every other transition.
    always_comb begin
        state_next = state;
        if (!enabled) begin
            state_next = DISABLED;
        end else begin
            case (state)
                DISABLED: state_next = RUN;
                RUN:      if (drain_in) state_next = DRAIN;
                DRAIN:    if (outstanding_count == '0) state_next = DONE;
                DONE:     if (!drain_in) state_next = RUN;
                default:  state_next = DISABLED;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            enabled           <= 1'b0;
            state             <= DISABLED;
            rr_ptr            <= '0;
            outstanding_count <= '0;
            issued_count      <= '0;
            out_valid         <= 1'b0;
            out_index         <= '0;
            out_data          <= '0;
            out_cu_id         <= '0;
        end else begin
            enabled <= enabled_in;
            state   <= state_next;
            if (accept) begin
                rr_ptr       <= rr_next;
                issued_count <= issued_count + 32'd1;
            end
            case ({accept, resp_eff})
                2'b10:   outstanding_count <= outstanding_count + CNT_W'(1);
                2'b01:   outstanding_count <= outstanding_count - CNT_W'(1);
                default: outstanding_count <= outstanding_count;
            endcase
            out_valid <= accept;
            out_index <= accept ? sel_index : '0;
            out_data  <= accept ? sel_data  : '0;
            out_cu_id <= accept ? sel_cu_id : '0;
        end
    end

endmodule

// File: tb/tb_cu_edge_data_write_arbiter.sv
// Directed bench for cu_edge_data_write_arbiter; granted writes are predicted
// into a queue and matched against the out_* beat one cycle later.
module tb_cu_edge_data_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MAX     = 16;
    localparam int CNT_W   = $clog2(MAX) + 1;

    logic                  clock;
    logic                  rst;
    logic                  enabled_in;
    logic                  drain_in;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_index;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ*8-1:0]  req_cu_id;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  write_buffer_full;
    logic                  write_response_valid;
    logic                  out_valid;
    logic [31:0]           out_index;
    logic [31:0]           out_data;
    logic [7:0]            out_cu_id;
    logic [CNT_W-1:0]      outstanding_count;
    logic [31:0]           issued_count;
    logic                  idle_out;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] data;
        logic [7:0]  cu;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_out = 0;
    logic [31:0] exp_issued = '0;

    cu_edge_data_write_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MAX_OUTSTANDING(MAX)
    ) dut (
        .clock(clock),
        .rst(rst),
        .enabled_in(enabled_in),
        .drain_in(drain_in),
        .req_valid(req_valid),
        .req_index(req_index),
        .req_data(req_data),
        .req_cu_id(req_cu_id),
        .req_ready(req_ready),
        .write_buffer_full(write_buffer_full),
        .write_response_valid(write_response_valid),
        .out_valid(out_valid),
        .out_index(out_index),
        .out_data(out_data),
        .out_cu_id(out_cu_id),
        .outstanding_count(outstanding_count),
        .issued_count(issued_count),
        .idle_out(idle_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Output monitor: every cycle must carry exactly the predicted beat or nothing.
    always @(posedge clock) begin
        #1;
        checks++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (out_valid !== 1'b1 || out_index !== mon_e.idx || out_data !== mon_e.data
                || out_cu_id !== mon_e.cu) begin
                errors++;
                $display("FAIL out_beat @%0t: got v=%b idx=%h data=%h cu=%h, expected v=1 idx=%h data=%h cu=%h",
                         $time, out_valid, out_index, out_data, out_cu_id, mon_e.idx, mon_e.data, mon_e.cu);
            end
        end else if (out_valid !== 1'b0 || out_index !== '0 || out_data !== '0 || out_cu_id !== '0) begin
            errors++;
            $display("FAIL out_quiet @%0t: got v=%b idx=%h data=%h cu=%h, expected all 0",
                     $time, out_valid, out_index, out_data, out_cu_id);
        end
    end

    task automatic set_payload(input int unsigned t);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_index[i*32 +: 32] = 32'h0100_0000 + 32'(t * 16 + i);
            req_data[i*32 +: 32]  = 32'hDA00_0000 ^ 32'(t << 8) ^ 32'(i);
            req_cu_id[i*8 +: 8]   = 8'(t * 4 + i);
        end
    endtask

    task automatic push_exp(input int unsigned i);
        exp_t e;
        e.idx  = req_index[i*32 +: 32];
        e.data = req_data[i*32 +: 32];
        e.cu   = req_cu_id[i*8 +: 8];
        exp_q.push_back(e);
        exp_out++;
        exp_issued = exp_issued + 32'd1;
    endtask

    task automatic respond(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clock);
            req_valid            = '0;
            write_response_valid = 1'b1;
            if (exp_out > 0) exp_out--;
        end
        @(negedge clock);
        write_response_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enabled_in = 1'b1; drain_in = 1'b0; req_valid = '1;
        write_buffer_full = 1'b0; write_response_valid = 1'b0; set_payload(0);
        repeat (2) @(negedge clock);
        checks++;
        if (req_ready !== '0 || outstanding_count !== '0 || issued_count !== '0 || idle_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b outstanding=%0d issued=%0d idle=%b, expected 0 0 0 0",
                     req_ready, outstanding_count, issued_count, idle_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL release_edge0: ready=%b, expected 0000", req_ready);
        end
        @(negedge clock); #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL release_edge1: ready=%b, expected 0000", req_ready);
        end
        @(negedge clock); #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL release_edge2: ready=%b, expected 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] er;
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clock);
            set_payload(k + 1);
            req_valid = '1;
            #1;
            er = 4'(1 << (k % 4));
            checks++;
            if (req_ready !== er) begin
                errors++; $display("FAIL rr_grant[%0d]: ready=%b, expected %b", k, req_ready, er);
            end
            push_exp(k % 4);
        end
        @(negedge clock);
        req_valid = '0;
        checks++;
        if (issued_count !== 32'd8 || outstanding_count !== CNT_W'(exp_out)) begin
            errors++;
            $display("FAIL rr_counts: issued=%0d outstanding=%0d, expected 8 %0d",
                     issued_count, outstanding_count, exp_out);
        end
        respond(8);
        checks++;
        if (outstanding_count !== '0) begin
            errors++; $display("FAIL rr_drained: outstanding=%0d, expected 0", outstanding_count);
        end
    endtask

    task automatic test_credit_limit();
        logic [3:0] er;
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge clock);
            set_payload(100 + k);
            req_valid = 4'b0100;
            #1;
            er = (k < 16) ? 4'b0100 : 4'b0000;
            checks++;
            if (req_ready !== er) begin
                errors++; $display("FAIL credit_ready[%0d]: ready=%b, expected %b", k, req_ready, er);
            end
            if (k < 16) push_exp(2);
        end
        @(negedge clock); #1;
        checks++;
        if (outstanding_count !== CNT_W'(16) || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL credit_full: outstanding=%0d ready=%b, expected 16 0000", outstanding_count, req_ready);
        end
        write_response_valid = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL credit_full_resp: ready=%b, expected 0000", req_ready);
        end
        @(negedge clock);
        write_response_valid = 1'b0;
        exp_out--;
        #1;
        checks++;
        if (outstanding_count !== CNT_W'(15) || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL credit_reopen: outstanding=%0d ready=%b, expected 15 0100", outstanding_count, req_ready);
        end
        push_exp(2);
        @(negedge clock); #1;
        checks++;
        if (outstanding_count !== CNT_W'(16) || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL credit_refill: outstanding=%0d ready=%b, expected 16 0000", outstanding_count, req_ready);
        end
        req_valid = '0;
        respond(16);
        checks++;
        if (outstanding_count !== '0 || issued_count !== exp_issued) begin
            errors++;
            $display("FAIL credit_end: outstanding=%0d issued=%0d, expected 0 %0d",
                     outstanding_count, issued_count, exp_issued);
        end
    endtask

    task automatic test_simultaneous();
        for (int unsigned k = 0; k < 5; k++) begin
            @(negedge clock);
            set_payload(200 + k);
            req_valid = 4'b0001;
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++; $display("FAIL simul_fill[%0d]: ready=%b, expected 0001", k, req_ready);
            end
            push_exp(0);
        end
        @(negedge clock); #1;
        checks++;
        if (outstanding_count !== CNT_W'(5)) begin
            errors++; $display("FAIL simul_pre: outstanding=%0d, expected 5", outstanding_count);
        end
        set_payload(205);
        write_response_valid = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL simul_ready: ready=%b, expected 0001", req_ready);
        end
        push_exp(0);
        exp_out--;
        @(negedge clock);
        req_valid = '0;
        write_response_valid = 1'b0;
        #1;
        checks++;
        if (outstanding_count !== CNT_W'(5)) begin
            errors++; $display("FAIL simul_both: outstanding=%0d, expected 5", outstanding_count);
        end
        respond(5);
        @(negedge clock);
        write_response_valid = 1'b1;
        @(negedge clock);
        write_response_valid = 1'b0;
        #1;
        checks++;
        if (outstanding_count !== '0) begin
            errors++; $display("FAIL simul_zero_resp: outstanding=%0d, expected 0", outstanding_count);
        end
    endtask

    task automatic test_backpressure();
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clock);
            set_payload(300 + k);
            req_valid = 4'b0010;
            write_buffer_full = 1'b1;
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_full[%0d]: ready=%b, expected 0000", k, req_ready);
            end
        end
        @(negedge clock);
        write_buffer_full = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release: ready=%b, expected 0010", req_ready);
        end
        push_exp(1);
        @(negedge clock);
        req_valid = '0;
        respond(1);
    endtask

    task automatic test_drain();
        int waited;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clock);
            set_payload(400 + k);
            req_valid = 4'b1000;
            #1;
            checks++;
            if (req_ready !== 4'b1000) begin
                errors++; $display("FAIL drain_fill[%0d]: ready=%b, expected 1000", k, req_ready);
            end
            push_exp(3);
        end
        @(negedge clock);
        req_valid = '0;
        drain_in = 1'b1;
        #1;
        checks++;
        if (outstanding_count !== CNT_W'(3)) begin
            errors++; $display("FAIL drain_pre: outstanding=%0d, expected 3", outstanding_count);
        end
        @(negedge clock);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || idle_out !== 1'b0) begin
            errors++; $display("FAIL drain_block: ready=%b idle=%b, expected 0000 0", req_ready, idle_out);
        end
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clock);
            write_response_valid = 1'b1;
            exp_out--;
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL drain_resp[%0d]: ready=%b, expected 0000", k, req_ready);
            end
        end
        @(negedge clock);
        write_response_valid = 1'b0;
        waited = 0;
        while (idle_out !== 1'b1 && waited < 4) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (idle_out !== 1'b1 || outstanding_count !== '0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL drain_idle: idle=%b outstanding=%0d ready=%b, expected 1 0 0000",
                     idle_out, outstanding_count, req_ready);
        end
        drain_in = 1'b0;
        @(negedge clock); #1;
        checks++;
        if (idle_out !== 1'b0 || req_ready !== 4'b1000) begin
            errors++; $display("FAIL drain_resume: idle=%b ready=%b, expected 0 1000", idle_out, req_ready);
        end
        push_exp(3);
        @(negedge clock);
        req_valid = '0;
        respond(1);
    endtask

    task automatic test_reset_mid();
        for (int unsigned k = 0; k < 7; k++) begin
            @(negedge clock);
            set_payload(500 + k);
            req_valid = 4'b0001;
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++; $display("FAIL rmid_fill[%0d]: ready=%b, expected 0001", k, req_ready);
            end
            push_exp(0);
        end
        @(negedge clock);
        req_valid = '1;
        #1;
        checks++;
        if (outstanding_count !== CNT_W'(7) || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rmid_pre: outstanding=%0d ready=%b, expected 7 0010", outstanding_count, req_ready);
        end
        rst = 1'b1;
        exp_out = 0;
        exp_issued = '0;
        #1;
        checks++;
        if (req_ready !== '0 || out_valid !== 1'b0 || out_index !== '0 || out_data !== '0
            || out_cu_id !== '0 || outstanding_count !== '0 || issued_count !== '0 || idle_out !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: ready=%b v=%b idx=%h data=%h cu=%h outstanding=%0d issued=%0d idle=%b, expected all 0",
                     req_ready, out_valid, out_index, out_data, out_cu_id, outstanding_count, issued_count, idle_out);
        end
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
        req_valid = '0;
        repeat (4) @(negedge clock);
        checks++;
        if (outstanding_count !== '0 || issued_count !== '0) begin
            errors++;
            $display("FAIL rmid_after: outstanding=%0d issued=%0d, expected 0 0", outstanding_count, issued_count);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_simultaneous();
        test_backpressure();
        test_drain();
        test_reset_mid();
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
